control_sequencer: RTL and testbench

Hardwired control unit for the 32-bit bus datapath. Fetches each instruction through the PC/MAR/MDR/IR path, decodes the 5-bit opcode and the register fields, and drives the one-hot bus-load and bus-drive strobes cycle by cycle. It sits beside the bus datapath and replaces the testbench-driven control signals. It waits on the RAM ready handshake and halts on a memory timeout.

---
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_control_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the 32-bit bus datapath.
// Optional single-step mode with CTRL_SINGLE_STEP_EN (adds step_i).
module control_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        clr_i,
   input  logic        run_i,
   input  logic [31:0] ir_i,
   input  logic        con_ff_i,
   input  logic        mem_ready_i,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic        step_i,
`endif
   output logic        pc_out_o,
   output logic        mar_in_o,
   output logic        inc_pc_o,
   output logic        pc_in_o,
   output logic        mdr_read_o,
   output logic        mdr_in_o,
   output logic        mdr_out_o,
   output logic        ir_in_o,
   output logic        alu_en_o,
   output logic        c_out_o,
   output logic        mem_write_o,
   output logic [15:0] reg_in_o,
   output logic [15:0] reg_out_o,
   output logic        in_port_out_o,
   output logic        out_port_in_o,
   output logic        halted_o,
   output logic        fault_o
);

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

   state_t      state_q, state_d, done;
   logic [7:0]  cnt_q, cnt_d;
   logic        fault_q, fault_d;
   logic        go, lim, mem_st;
   logic [4:0]  op;
   logic [15:0] ra_oh;
   logic        is_alu, is_ld, is_st, is_br, is_in, is_out, is_halt;
   logic        unused_ir;

   assign op        = ir_i[31:27];
   assign ra_oh     = 16'h0001 << ir_i[26:23];
   assign unused_ir = ^ir_i[18:0];
   assign is_alu    = !op[4] || op[4:2] == 3'b100;
   assign is_ld     = op[4:1] == 4'b1010;
   assign is_st     = op == 5'b10110;
   assign is_br     = op[4:2] == 3'b110;
   assign is_in     = op == 5'b11100;
   assign is_out    = op == 5'b11101;
   assign is_halt   = op == 5'b11111;
   assign lim       = cnt_q == 8'(MEM_TIMEOUT - 1);
   assign mem_st    = state_q == T1 || (state_q == T4 && !is_alu);
   assign fault_o   = fault_q;

`ifdef CTRL_SINGLE_STEP_EN
   // One instruction per rising edge of step_i; every boundary parks in IDLE.
   logic step_q;
   assign go   = run_i && step_i && !step_q;
   assign done = IDLE;
   always_ff @(posedge clk_i or negedge clr_i)
      if (!clr_i) step_q <= 1'b0;
      else        step_q <= step_i;
`else
   assign go   = run_i;
   assign done = run_i ? T0 : IDLE;
`endif

   always_ff @(posedge clk_i or negedge clr_i)
      if (!clr_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end

   always_comb begin
      state_d       = state_q;
      cnt_d         = '0;
      fault_d       = fault_q;
      pc_out_o      = 1'b0;
      mar_in_o      = 1'b0;
      inc_pc_o      = 1'b0;
      pc_in_o       = 1'b0;
      mdr_read_o    = 1'b0;
      mdr_in_o      = 1'b0;
      mdr_out_o     = 1'b0;
      ir_in_o       = 1'b0;
      alu_en_o      = 1'b0;
      c_out_o       = 1'b0;
      mem_write_o   = 1'b0;
      reg_in_o      = '0;
      reg_out_o     = '0;
      in_port_out_o = 1'b0;
      out_port_in_o = 1'b0;
      halted_o      = 1'b0;
      case (state_q)
         IDLE: state_d = go ? T0 : IDLE;
         T0: begin
            pc_out_o = 1'b1;
            mar_in_o = 1'b1;
            inc_pc_o = 1'b1;
            state_d  = T1;
         end
         T1: begin
            mdr_read_o = 1'b1;
            mdr_in_o   = 1'b1;
            state_d    = T2;
         end
         T2: begin
            mdr_out_o = 1'b1;
            ir_in_o   = 1'b1;
            state_d   = T3;
         end
         T3: begin
            state_d = done;
            if (is_alu) begin
               alu_en_o = 1'b1;
               state_d  = T4;
            end else if (is_ld || is_st) begin
               mar_in_o = 1'b1;
               state_d  = T4;
            end else if (is_br) pc_in_o = con_ff_i;
            else if (is_in) begin
               in_port_out_o = 1'b1;
               reg_in_o      = ra_oh;
            end else if (is_out) begin
               reg_out_o     = ra_oh;
               out_port_in_o = 1'b1;
            end else if (is_halt) state_d = HALT;
         end
         T4: begin
            state_d = done;
            if (is_alu) begin
               c_out_o  = 1'b1;
               reg_in_o = ra_oh;
            end else if (is_ld) begin
               mdr_read_o = 1'b1;
               mdr_in_o   = 1'b1;
               state_d    = T5;
            end else mem_write_o = 1'b1;
         end
         T5: begin
            mdr_out_o = 1'b1;
            reg_in_o  = ra_oh;
            state_d   = done;
         end
         HALT: halted_o = 1'b1;
         default: state_d = IDLE;
      endcase
      // A ready memory always wins over the timeout on the same cycle.
      if (mem_st && !mem_ready_i) begin
         cnt_d   = cnt_q + 8'd1;
         state_d = lim ? HALT : state_q;
         fault_d = fault_q | lim;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench for control_sequencer (default build).
module tb_control_sequencer;

   localparam logic [14:0] S_PCO  = 15'h4000, S_MARI = 15'h2000, S_INC  = 15'h1000;
   localparam logic [14:0] S_PCI  = 15'h0800, S_MDRR = 15'h0400, S_MDRI = 15'h0200;
   localparam logic [14:0] S_MDRO = 15'h0100, S_IRI  = 15'h0080, S_ALU  = 15'h0040;
   localparam logic [14:0] S_CO   = 15'h0020, S_MW   = 15'h0010, S_INP  = 15'h0008;
   localparam logic [14:0] S_OUTP = 15'h0004, S_HLT  = 15'h0002, S_FLT  = 15'h0001;

   typedef struct packed {
      logic [63:0] tag;
      logic        rn, mr, cf;
      logic [31:0] ir;
      logic [46:0] exp;
   } ent_t;

   logic        clk_i = 1'b0, clr_i, run_i, con_ff_i, mem_ready_i, step_i;
   logic [31:0] ir_i;
   logic        pc_out_o, mar_in_o, inc_pc_o, pc_in_o, mdr_read_o, mdr_in_o, mdr_out_o, ir_in_o;
   logic        alu_en_o, c_out_o, mem_write_o, in_port_out_o, out_port_in_o, halted_o, fault_o;
   logic [15:0] reg_in_o, reg_out_o;
   logic [46:0] obs;
   ent_t        q[$];
   int          vecs = 0, errs = 0;

   control_sequencer #(.MEM_TIMEOUT(15)) dut (
      .clk_i(clk_i), .clr_i(clr_i), .run_i(run_i), .ir_i(ir_i), .con_ff_i(con_ff_i),
      .mem_ready_i(mem_ready_i),
`ifdef CTRL_SINGLE_STEP_EN
      .step_i(step_i),
`endif
      .pc_out_o(pc_out_o), .mar_in_o(mar_in_o), .inc_pc_o(inc_pc_o), .pc_in_o(pc_in_o),
      .mdr_read_o(mdr_read_o), .mdr_in_o(mdr_in_o), .mdr_out_o(mdr_out_o), .ir_in_o(ir_in_o),
      .alu_en_o(alu_en_o), .c_out_o(c_out_o), .mem_write_o(mem_write_o),
      .reg_in_o(reg_in_o), .reg_out_o(reg_out_o),
      .in_port_out_o(in_port_out_o), .out_port_in_o(out_port_in_o),
      .halted_o(halted_o), .fault_o(fault_o)
   );

   always #5 clk_i = ~clk_i;

   assign obs = {pc_out_o, mar_in_o, inc_pc_o, pc_in_o, mdr_read_o, mdr_in_o, mdr_out_o, ir_in_o,
                 alu_en_o, c_out_o, mem_write_o, in_port_out_o, out_port_in_o, halted_o, fault_o,
                 reg_in_o, reg_out_o};

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra);
      return {op, ra, 23'd0};
   endfunction

   task automatic push(input logic [63:0] tag, input logic rn, mr, cf, input logic [31:0] ir,
                       input logic [14:0] s, input logic [15:0] ri, ro);
      ent_t e;
      e.tag = tag; e.rn = rn; e.mr = mr; e.cf = cf; e.ir = ir; e.exp = {s, ri, ro};
      q.push_back(e);
   endtask

   task automatic fetch(input logic [63:0] tag, input logic [31:0] ir, input int waits);
      push(tag, 1, 0, 0, ir, S_PCO | S_MARI | S_INC, 0, 0);
      repeat (waits) push(tag, 1, 0, 0, ir, S_MDRR | S_MDRI, 0, 0);
      push(tag, 1, 1, 0, ir, S_MDRR | S_MDRI, 0, 0);
      push(tag, 1, 0, 0, ir, S_MDRO | S_IRI, 0, 0);
   endtask

   task automatic check_now(input logic [63:0] tag, input logic [46:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered at a falling edge; applies each entry's inputs, checks, moves to next falling edge.
   task automatic drain();
      ent_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         run_i = e.rn; mem_ready_i = e.mr; con_ff_i = e.cf; ir_i = e.ir;
         #1 check_now(e.tag, e.exp);
         @(negedge clk_i);
      end
   endtask

   initial begin
      clr_i = 1'b0; run_i = 1'b0; con_ff_i = 1'b0; mem_ready_i = 1'b0; step_i = 1'b0; ir_i = '0;
      #1 check_now("reset", '0);
      @(negedge clk_i);
      clr_i = 1'b1;
      push("idle", 1, 0, 0, 0, 0, 0, 0);
      fetch("add_f", mk(5'b00011, 3), 0);
      push("add_t3", 1, 0, 0, mk(5'b00011, 3), S_ALU, 0, 0);
      push("add_t4", 1, 0, 0, mk(5'b00011, 3), S_CO, 16'h0008, 0);
      fetch("ld_f", mk(5'b10101, 5), 0);
      push("ld_t3", 1, 0, 0, mk(5'b10101, 5), S_MARI, 0, 0);
      repeat (3) push("ld_t4w", 1, 0, 0, mk(5'b10101, 5), S_MDRR | S_MDRI, 0, 0);
      push("ld_t4", 1, 1, 0, mk(5'b10101, 5), S_MDRR | S_MDRI, 0, 0);
      push("ld_t5", 1, 0, 0, mk(5'b10101, 5), S_MDRO, 16'h0020, 0);
      fetch("brt_f", mk(5'b11000, 0), 0);
      push("brt_t3", 1, 0, 1, mk(5'b11000, 0), S_PCI, 0, 0);
      fetch("brf_f", mk(5'b11000, 0), 0);
      push("brf_t3", 1, 0, 0, mk(5'b11000, 0), 0, 0, 0);
      fetch("in_f", mk(5'b11100, 2), 0);
      push("in_t3", 1, 0, 0, mk(5'b11100, 2), S_INP, 16'h0004, 0);
      fetch("out_f", mk(5'b11101, 7), 0);
      push("out_t3", 1, 0, 0, mk(5'b11101, 7), S_OUTP, 0, 16'h0080);
      fetch("nop_f", mk(5'b11110, 9), 0);
      push("nop_t3", 1, 0, 0, mk(5'b11110, 9), 0, 0, 0);
      fetch("rsv_f", mk(5'b10111, 4), 0);
      push("rsv_t3", 1, 0, 0, mk(5'b10111, 4), 0, 0, 0);
      fetch("ldi_f14", mk(5'b10100, 15), 14);
      push("ldi_t3", 1, 0, 0, mk(5'b10100, 15), S_MARI, 0, 0);
      push("ldi_t4", 1, 1, 0, mk(5'b10100, 15), S_MDRR | S_MDRI, 0, 0);
      push("ldi_t5", 1, 0, 0, mk(5'b10100, 15), S_MDRO, 16'h8000, 0);
      fetch("st_f", mk(5'b10110, 1), 0);
      push("st_t3", 1, 0, 0, mk(5'b10110, 1), S_MARI, 0, 0);
      push("st_t4w", 0, 0, 0, mk(5'b10110, 1), S_MW, 0, 0);
      push("st_t4", 0, 1, 0, mk(5'b10110, 1), S_MW, 0, 0);
      repeat (2) push("st_idle", 0, 0, 0, mk(5'b10110, 1), 0, 0, 0);
      push("idle2", 1, 0, 0, 0, 0, 0, 0);
      push("abt_t0", 1, 0, 0, mk(5'b00001, 1), S_PCO | S_MARI | S_INC, 0, 0);
      push("abt_t1", 1, 1, 0, mk(5'b00001, 1), S_MDRR | S_MDRI, 0, 0);
      drain();
      #1 check_now("abt_t2", {S_MDRO | S_IRI, 16'h0, 16'h0});
      #1 clr_i = 1'b0;
      #1 check_now("clr_async", '0);
      @(negedge clk_i);
      clr_i = 1'b1;
      push("idle3", 1, 0, 0, 0, 0, 0, 0);
      push("to_t0", 1, 0, 0, mk(5'b00010, 6), S_PCO | S_MARI | S_INC, 0, 0);
      repeat (15) push("to_t1", 1, 0, 0, mk(5'b00010, 6), S_MDRR | S_MDRI, 0, 0);
      repeat (3) push("to_halt", 1, 1, 0, mk(5'b00010, 6), S_HLT | S_FLT, 0, 0);
      drain();
      clr_i = 1'b0;
      #1 check_now("clr_fault", '0);
      @(negedge clk_i);
      clr_i = 1'b1;
      push("idle4", 1, 0, 0, 0, 0, 0, 0);
      fetch("hlt_f", mk(5'b11111, 0), 0);
      push("hlt_t3", 1, 0, 0, mk(5'b11111, 0), 0, 0, 0);
      repeat (3) push("hlt_st", 1, 1, 0, mk(5'b11111, 0), S_HLT, 0, 0);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
